// File: rtl/can_frame_receiver_pkg.sv
// Shared CAN receiver definitions: receive FSM states, field lengths,
// CRC-15 polynomial and the DLC-to-payload helper.
package can_defs;

  typedef enum logic [3:0] {
    RX_IDLE,
    RX_ID_STD,
    RX_RTR_1,
    RX_IDE,
    RX_ID_EXT,
    RX_RTR_2,
    RX_R_1,
    RX_R_0,
    RX_DLC,
    RX_DATA,
    RX_CRC,
    RX_CRC_DELIM,
    RX_ACK,
    RX_ACK_DELIM,
    RX_EOF,
    RX_IFS
  } rx_state_e;

  localparam int ID_STD_LEN = 11;
  localparam int ID_EXT_LEN = 18;
  localparam int DLC_LEN    = 4;
  localparam int CRC_LEN    = 15;
  localparam int EOF_LEN    = 7;
  localparam int IFS_LEN    = 3;

  localparam logic [14:0] CRC_POLY  = 15'h4599;
  localparam logic [3:0]  MAX_BYTES = 4'd8;

  // Index of the last bit of a field, sized for the 6-bit bit counter.
  function automatic logic [5:0] last_idx(input int len);
    return 6'(len - 1);
  endfunction

  // Remote frames carry no payload; DLC values above 8 still mean 8 bytes.
  function automatic logic [3:0] payload_bytes(input logic rtr, input logic [3:0] dlc);
    if (rtr)
      return 4'd0;
    else if (dlc > MAX_BYTES)
      return MAX_BYTES;
    else
      return dlc;
  endfunction

endpackage

// File: rtl/can_frame_receiver_if.sv
// Bus-side strobes and decoded frame fields of the CAN frame receiver.
// master = receiver, slave = bit-timing logic / RX buffer side.
interface can_frame_receiver_if;
  import can_defs::*;

  logic                  rx_enable;
  logic                  sample_point;
  logic                  rx_abort;
  logic                  rx_bit;

  logic [ID_STD_LEN-1:0] rx_id_std;
  logic [ID_EXT_LEN-1:0] rx_id_ext;
  logic                  rx_ide;
  logic                  rx_rtr;
  logic [DLC_LEN-1:0]    rx_dlc;
  logic [7:0]            rx_data [0:7];
  logic [CRC_LEN-1:0]    rx_crc;
  logic                  ack_drive;
  logic                  rx_busy;
  logic                  rx_done;
  logic                  form_err;
  logic                  crc_err;

  modport master (
    input  rx_enable, sample_point, rx_abort, rx_bit,
    output rx_id_std, rx_id_ext, rx_ide, rx_rtr, rx_dlc, rx_data, rx_crc,
           ack_drive, rx_busy, rx_done, form_err, crc_err
  );

  modport slave (
    output rx_enable, sample_point, rx_abort, rx_bit,
    input  rx_id_std, rx_id_ext, rx_ide, rx_rtr, rx_dlc, rx_data, rx_crc,
           ack_drive, rx_busy, rx_done, form_err, crc_err
  );

endinterface

// File: rtl/can_frame_receiver_crc15.sv
// Serial CAN CRC-15 (init 0), one bit per bit_en_i; clear_i wins over bit_en_i.
module can_crc15
  import can_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        bit_en_i,
  input  logic        bit_i,
  output logic [14:0] crc_o
);

  logic [14:0] crc_q, crc_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (bit_en_i) begin
      crc_d = {crc_q[13:0], 1'b0};
      if (bit_i ^ crc_q[14])
        crc_d = crc_d ^ CRC_POLY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc_q <= '0;
    else
      crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/can_frame_receiver.sv
// Bit-level CAN 2.0A/2.0B frame receiver. Define CAN_RX_CRC_CHECK_EN to add
// the CRC-15 engine and crc_err reporting; otherwise crc_err is tied low.
module can_frame_receiver
  import can_defs::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  can_frame_receiver_if.master  bus
);

  rx_state_e             state_q;
  logic [5:0]            bit_cnt_q;
  logic [3:0]            byte_cnt_q;
  logic [3:0]            payload_q;

  logic [ID_STD_LEN-1:0] rx_id_std_q;
  logic [ID_EXT_LEN-1:0] rx_id_ext_q;
  logic                  rx_ide_q;
  logic                  rx_rtr_q;
  logic [DLC_LEN-1:0]    rx_dlc_q;
  logic [7:0]            rx_data_q [0:7];
  logic [CRC_LEN-1:0]    rx_crc_q;
  logic                  ack_drive_q;
  logic                  rx_busy_q;
  logic                  rx_done_q;
  logic                  form_err_q;

  logic                  sp;
  logic                  bit_in;
  logic [3:0]            dlc_payload;

  assign sp          = bus.sample_point;
  assign bit_in      = bus.rx_bit;
  // Payload size decided while the last DLC bit is being sampled.
  assign dlc_payload = payload_bytes(rx_rtr_q, {rx_dlc_q[2:0], bit_in});

`ifdef CAN_RX_CRC_CHECK_EN
  logic        crc_clear;
  logic        crc_bit_en;
  logic [14:0] crc_calc;
  logic        crc_err_q;

  assign crc_clear  = sp & ~bus.rx_abort & (state_q == RX_IDLE) & bus.rx_enable & ~bit_in;
  // SOF itself is a zero into a cleared register, so starting at ID_STD is equivalent.
  assign crc_bit_en = sp & ~bus.rx_abort &
                      (state_q inside {RX_ID_STD, RX_RTR_1, RX_IDE, RX_ID_EXT, RX_RTR_2,
                                       RX_R_1, RX_R_0, RX_DLC, RX_DATA});

  can_crc15 u_crc15 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (crc_clear),
    .bit_en_i (crc_bit_en),
    .bit_i    (bit_in),
    .crc_o    (crc_calc)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      payload_q   <= '0;
      rx_id_std_q <= '0;
      rx_id_ext_q <= '0;
      rx_ide_q    <= 1'b0;
      rx_rtr_q    <= 1'b0;
      rx_dlc_q    <= '0;
      // NOTE: the payload bytes are visible outputs with defined reset values, so this small array is reset like any flop.
      rx_data_q   <= '{default: 8'h00};
      rx_crc_q    <= '0;
      ack_drive_q <= 1'b0;
      rx_busy_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      form_err_q  <= 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
      crc_err_q   <= 1'b0;
`endif
    end else begin
      rx_done_q  <= 1'b0;
      form_err_q <= 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
      crc_err_q  <= 1'b0;
`endif
      if (bus.rx_abort) begin
        state_q     <= RX_IDLE;
        bit_cnt_q   <= '0;
        byte_cnt_q  <= '0;
        ack_drive_q <= 1'b0;
        rx_busy_q   <= 1'b0;
      end else if (sp) begin
        bit_cnt_q <= bit_cnt_q + 6'd1;
        unique case (state_q)
          RX_IDLE: begin
            bit_cnt_q <= '0;
            if (bus.rx_enable && !bit_in) begin
              state_q     <= RX_ID_STD;
              rx_busy_q   <= 1'b1;
              byte_cnt_q  <= '0;
              rx_id_ext_q <= '0;
              rx_data_q   <= '{default: 8'h00};
            end
          end
          RX_ID_STD: begin
            rx_id_std_q <= {rx_id_std_q[ID_STD_LEN-2:0], bit_in};
            if (bit_cnt_q == last_idx(ID_STD_LEN)) begin
              bit_cnt_q <= '0;
              state_q   <= RX_RTR_1;
            end
          end
          RX_RTR_1: begin
            rx_rtr_q <= bit_in;
            state_q  <= RX_IDE;
          end
          RX_IDE: begin
            rx_ide_q  <= bit_in;
            bit_cnt_q <= '0;
            state_q   <= bit_in ? RX_ID_EXT : RX_R_0;
          end
          RX_ID_EXT: begin
            rx_id_ext_q <= {rx_id_ext_q[ID_EXT_LEN-2:0], bit_in};
            if (bit_cnt_q == last_idx(ID_EXT_LEN)) begin
              bit_cnt_q <= '0;
              state_q   <= RX_RTR_2;
            end
          end
          RX_RTR_2: begin
            rx_rtr_q <= bit_in;
            state_q  <= RX_R_1;
          end
          RX_R_1: state_q <= RX_R_0;
          RX_R_0: begin
            bit_cnt_q <= '0;
            state_q   <= RX_DLC;
          end
          RX_DLC: begin
            rx_dlc_q <= {rx_dlc_q[2:0], bit_in};
            if (bit_cnt_q == last_idx(DLC_LEN)) begin
              bit_cnt_q  <= '0;
              byte_cnt_q <= '0;
              payload_q  <= dlc_payload;
              state_q    <= (dlc_payload == 4'd0) ? RX_CRC : RX_DATA;
            end
          end
          RX_DATA: begin
            rx_data_q[byte_cnt_q[2:0]] <= {rx_data_q[byte_cnt_q[2:0]][6:0], bit_in};
            if (bit_cnt_q == 6'd7) begin
              bit_cnt_q  <= '0;
              byte_cnt_q <= byte_cnt_q + 4'd1;
              if (byte_cnt_q + 4'd1 == payload_q)
                state_q <= RX_CRC;
            end
          end
          RX_CRC: begin
            rx_crc_q <= {rx_crc_q[CRC_LEN-2:0], bit_in};
            if (bit_cnt_q == last_idx(CRC_LEN)) begin
              bit_cnt_q <= '0;
              state_q   <= RX_CRC_DELIM;
            end
          end
          RX_CRC_DELIM: begin
            if (!bit_in) begin
              form_err_q <= 1'b1;
              rx_busy_q  <= 1'b0;
              state_q    <= RX_IDLE;
`ifdef CAN_RX_CRC_CHECK_EN
            end else if (rx_crc_q != crc_calc) begin
              crc_err_q <= 1'b1;
              rx_busy_q <= 1'b0;
              state_q   <= RX_IDLE;
`endif
            end else begin
              ack_drive_q <= 1'b1;
              state_q     <= RX_ACK;
            end
          end
          RX_ACK: begin
            ack_drive_q <= 1'b0;
            state_q     <= RX_ACK_DELIM;
          end
          RX_ACK_DELIM: begin
            bit_cnt_q <= '0;
            if (!bit_in) begin
              form_err_q <= 1'b1;
              rx_busy_q  <= 1'b0;
              state_q    <= RX_IDLE;
            end else begin
              state_q <= RX_EOF;
            end
          end
          RX_EOF: begin
            if (!bit_in) begin
              form_err_q <= 1'b1;
              rx_busy_q  <= 1'b0;
              state_q    <= RX_IDLE;
            end else if (bit_cnt_q == last_idx(EOF_LEN)) begin
              rx_done_q <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= RX_IFS;
            end
          end
          RX_IFS: begin
            if (bit_cnt_q == last_idx(IFS_LEN)) begin
              bit_cnt_q <= '0;
              rx_busy_q <= 1'b0;
              state_q   <= RX_IDLE;
            end
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_id_std = rx_id_std_q;
  assign bus.rx_id_ext = rx_id_ext_q;
  assign bus.rx_ide    = rx_ide_q;
  assign bus.rx_rtr    = rx_rtr_q;
  assign bus.rx_dlc    = rx_dlc_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_crc    = rx_crc_q;
  assign bus.ack_drive = ack_drive_q;
  assign bus.rx_busy   = rx_busy_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.form_err  = form_err_q;
`ifdef CAN_RX_CRC_CHECK_EN
  assign bus.crc_err   = crc_err_q;
`else
  assign bus.crc_err   = 1'b0;
`endif

endmodule

// File: tb/tb_can_frame_receiver.sv
// Directed bench for can_frame_receiver: builds destuffed frames bit by bit
// and checks decoded fields, ACK timing and completion/error pulses.
module tb_can_frame_receiver;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  can_frame_receiver_if bus ();

  can_frame_receiver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Free-running event counters; tests compare deltas around each frame.
  int n_done = 0, n_form = 0, n_crc = 0, n_ack = 0;
  always @(negedge clk) begin
    if (bus.rx_done)   n_done <= n_done + 1;
    if (bus.form_err)  n_form <= n_form + 1;
    if (bus.crc_err)   n_crc  <= n_crc + 1;
    if (bus.ack_drive) n_ack  <= n_ack + 1;
  end

  int s_done, s_form, s_crc, s_ack;
  task automatic snap();
    s_done = n_done; s_form = n_form; s_crc = n_crc; s_ack = n_ack;
  endtask

  logic        frame_q [$];
  int          crc_pos, eof_pos, ack_pos;
  logic [14:0] exp_crc;

  task automatic push_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frame_q.push_back(v[i]);
  endtask

  function automatic logic [14:0] crc_over(input int n);
    logic [14:0] c = '0;
    logic        nxt;
    for (int i = 0; i < n; i++) begin
      nxt = frame_q[i] ^ c[14];
      c   = {c[13:0], 1'b0};
      if (nxt) c = c ^ 15'h4599;
    end
    return c;
  endfunction

  // data holds byte 0 in bits [63:56]; nbytes is the hand-derived payload size.
  task automatic build(input logic ide, input logic [10:0] ids, input logic [17:0] idx,
                       input logic rtr, input logic [3:0] dlc, input logic [63:0] data,
                       input int nbytes);
    frame_q.delete();
    frame_q.push_back(1'b0);
    push_bits(64'(ids), 11);
    if (ide) begin
      frame_q.push_back(1'b1);
      frame_q.push_back(1'b1);
      push_bits(64'(idx), 18);
      frame_q.push_back(rtr);
      frame_q.push_back(1'b0);
      frame_q.push_back(1'b0);
    end else begin
      frame_q.push_back(rtr);
      frame_q.push_back(1'b0);
      frame_q.push_back(1'b0);
    end
    push_bits(64'(dlc), 4);
    for (int k = 0; k < nbytes; k++)
      for (int m = 0; m < 8; m++) frame_q.push_back(data[63 - 8*k - m]);
    crc_pos = frame_q.size();
    exp_crc = crc_over(crc_pos);
    push_bits(64'(exp_crc), 15);
    frame_q.push_back(1'b1);
    ack_pos = frame_q.size();
    frame_q.push_back(1'b1);
    frame_q.push_back(1'b1);
    eof_pos = frame_q.size();
    push_bits(64'h7f, 7);
    push_bits(64'h7, 3);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sample_point = 1'b1;
      bus.rx_bit       = frame_q[i];
      @(negedge clk);
      bus.sample_point = 1'b0;
      bus.rx_bit       = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.rx_enable    = 1'b1;
    bus.sample_point = 1'b0;
    bus.rx_abort     = 1'b0;
    bus.rx_bit       = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_id_std", 64'(bus.rx_id_std), 64'h0);
    check("rst_busy", 64'(bus.rx_busy), 64'h0);
    check("rst_ack", 64'(bus.ack_drive), 64'h0);
    check("rst_dlc", 64'(bus.rx_dlc), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // rx_enable low: a dominant bit must not start a frame.
    bus.rx_enable = 1'b0;
    build(1'b0, 11'h000, 18'h0, 1'b0, 4'd0, 64'h0, 0);
    send_bits(1);
    check("no_enable_busy", 64'(bus.rx_busy), 64'h0);
    bus.rx_enable = 1'b1;

    // Standard data frame, ID 0x123, AA 55.
    build(1'b0, 11'h123, 18'h0, 1'b0, 4'd2, 64'hAA55_0000_0000_0000, 2);
    snap();
    send_bits(frame_q.size());
    check("std_id", 64'(bus.rx_id_std), 64'h123);
    check("std_ide", 64'(bus.rx_ide), 64'h0);
    check("std_rtr", 64'(bus.rx_rtr), 64'h0);
    check("std_ext", 64'(bus.rx_id_ext), 64'h0);
    check("std_dlc", 64'(bus.rx_dlc), 64'h2);
    check("std_d0", 64'(bus.rx_data[0]), 64'hAA);
    check("std_d1", 64'(bus.rx_data[1]), 64'h55);
    check("std_d2", 64'(bus.rx_data[2]), 64'h00);
    check("std_crc", 64'(bus.rx_crc), 64'(exp_crc));
    check("std_done", 64'(n_done - s_done), 64'd1);
    check("std_ack_cycles", 64'(n_ack - s_ack), 64'd2);
    check("std_form", 64'(n_form - s_form), 64'd0);
    check("std_busy_end", 64'(bus.rx_busy), 64'h0);

    // Extended frame: SRR is 1 but RTR_2 is 0, so rx_rtr must end at 0.
    build(1'b1, 11'h7FF, 18'h2AAAA, 1'b0, 4'd8, 64'h0102_0304_0506_0708, 8);
    snap();
    send_bits(frame_q.size());
    check("ext_id_std", 64'(bus.rx_id_std), 64'h7FF);
    check("ext_id_ext", 64'(bus.rx_id_ext), 64'h2AAAA);
    check("ext_ide", 64'(bus.rx_ide), 64'h1);
    check("ext_rtr", 64'(bus.rx_rtr), 64'h0);
    check("ext_dlc", 64'(bus.rx_dlc), 64'h8);
    check("ext_d0", 64'(bus.rx_data[0]), 64'h01);
    check("ext_d4", 64'(bus.rx_data[4]), 64'h05);
    check("ext_d7", 64'(bus.rx_data[7]), 64'h08);
    check("ext_done", 64'(n_done - s_done), 64'd1);

    // Remote frame, DLC 4: no data bits on the bus, data registers cleared at SOF.
    build(1'b0, 11'h321, 18'h0, 1'b1, 4'd4, 64'h0, 0);
    snap();
    send_bits(frame_q.size());
    check("rtr_rtr", 64'(bus.rx_rtr), 64'h1);
    check("rtr_dlc", 64'(bus.rx_dlc), 64'h4);
    check("rtr_ext_cleared", 64'(bus.rx_id_ext), 64'h0);
    check("rtr_d0", 64'(bus.rx_data[0]), 64'h00);
    check("rtr_d7", 64'(bus.rx_data[7]), 64'h00);
    check("rtr_done", 64'(n_done - s_done), 64'd1);

    // DLC 15 clamps to 8 payload bytes.
    build(1'b0, 11'h00F, 18'h0, 1'b0, 4'd15, 64'h1122_3344_5566_7788, 8);
    snap();
    send_bits(frame_q.size());
    check("dlc15_dlc", 64'(bus.rx_dlc), 64'hF);
    check("dlc15_d7", 64'(bus.rx_data[7]), 64'h88);
    check("dlc15_done", 64'(n_done - s_done), 64'd1);
    check("dlc15_form", 64'(n_form - s_form), 64'd0);

    // One received CRC bit flipped.
    build(1'b0, 11'h456, 18'h0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, 1);
    frame_q[crc_pos + 4] = ~frame_q[crc_pos + 4];
    snap();
    send_bits(frame_q.size());
`ifdef CAN_RX_CRC_CHECK_EN
    check("crcbad_err", 64'(n_crc - s_crc), 64'd1);
    check("crcbad_ack", 64'(n_ack - s_ack), 64'd0);
    check("crcbad_done", 64'(n_done - s_done), 64'd0);
`else
    check("crcbad_err", 64'(n_crc - s_crc), 64'd0);
    check("crcbad_ack", 64'(n_ack - s_ack), 64'd2);
    check("crcbad_done", 64'(n_done - s_done), 64'd1);
`endif
    check("crcbad_busy", 64'(bus.rx_busy), 64'h0);
    build(1'b0, 11'h457, 18'h0, 1'b0, 4'd0, 64'h0, 0);
    snap();
    send_bits(frame_q.size());
    check("after_crc_id", 64'(bus.rx_id_std), 64'h457);
    check("after_crc_done", 64'(n_done - s_done), 64'd1);

    // EOF bit 3 dominant.
    build(1'b0, 11'h234, 18'h0, 1'b0, 4'd1, 64'h5A00_0000_0000_0000, 1);
    frame_q[eof_pos + 2] = 1'b0;
    snap();
    send_bits(frame_q.size());
    check("eof_form", 64'(n_form - s_form), 64'd1);
    check("eof_done", 64'(n_done - s_done), 64'd0);
    check("eof_ack_cycles", 64'(n_ack - s_ack), 64'd2);
    check("eof_busy", 64'(bus.rx_busy), 64'h0);

    // rx_abort mid-DATA, coincident with a sample_point.
    build(1'b0, 11'h155, 18'h0, 1'b0, 4'd3, 64'hDEAD_BE00_0000_0000, 3);
    snap();
    send_bits(24);
    check("abort_busy_before", 64'(bus.rx_busy), 64'h1);
    bus.rx_abort     = 1'b1;
    bus.sample_point = 1'b1;
    bus.rx_bit       = 1'b0;
    @(negedge clk);
    bus.rx_abort     = 1'b0;
    bus.sample_point = 1'b0;
    bus.rx_bit       = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.rx_busy), 64'h0);
    check("abort_id_hold", 64'(bus.rx_id_std), 64'h155);
    check("abort_pulses", 64'((n_done - s_done) + (n_form - s_form) + (n_crc - s_crc)), 64'd0);
    check("abort_ack", 64'(bus.ack_drive), 64'h0);
    send_bits(frame_q.size());
    check("abort_recover_d2", 64'(bus.rx_data[2]), 64'hBE);
    check("abort_recover_done", 64'(n_done - s_done), 64'd1);

    // rst_n mid-DATA.
    build(1'b0, 11'h6A5, 18'h0, 1'b0, 4'd2, 64'hF00F_0000_0000_0000, 2);
    send_bits(26);
    check("rst_mid_busy_before", 64'(bus.rx_busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_id", 64'(bus.rx_id_std), 64'h0);
    check("rst_mid_d0", 64'(bus.rx_data[0]), 64'h0);
    check("rst_mid_dlc", 64'(bus.rx_dlc), 64'h0);
    check("rst_mid_busy", 64'(bus.rx_busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
